// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issue-side sequencer for the combinational 8-bit ALU.
//
// This block accepts one 16-bit instruction over a valid/ready handshake. It reads
// its operands from a 4-entry register file (r0 is hardwired to zero). It drives
// registered operands and an opcode to an external combinational ALU. It captures
// the ALU result and zero flag, then writes the result back. Each instruction
// visits IDLE, DECODE, EXEC and WB for one cycle each.
//
// Instruction word:
//   [15:13] op   [12] use_imm   [11:10] rd   [9:8] rs1   [7:6] rs2   [7:0] imm
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       instruction offered
//   in_instr       instruction word, sampled only on the handshake edge
//   in_ready       high only in IDLE (decoded from state alone)
//   alu_a/b/op     registered ALU operands and opcode
//   alu_r/zero     combinational ALU result and zero flag
//   out_valid      1-cycle retire pulse
//   out_illegal    1-cycle pulse together with out_valid for an illegal opcode
//   out_result     last legal result written (held)
//   out_zero       zero flag of last legal retire (held)
//   dbg_sel/data   combinational register-file read port
//   zero_cnt       (ALU_SEQ_ZERO_CNT_EN only) saturating count of legal zero retires
//
// Build option: define ALU_SEQ_ZERO_CNT_EN to add the zero_cnt port and its counter.

module alu_seq_ctrl #(
    parameter int unsigned     BITS      = 8,
    parameter logic [BITS-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [15:0]     in_instr,
    output logic            in_ready,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [2:0]      alu_op,
    input  logic [BITS-1:0] alu_r,
    input  logic            alu_zero,
    output logic            out_valid,
    output logic [BITS-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    input  logic [1:0]      dbg_sel,
    output logic [BITS-1:0] dbg_data
`ifdef ALU_SEQ_ZERO_CNT_EN
    ,
    output logic [7:0]      zero_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e          state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [BITS-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [BITS-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [BITS-1:0] res_q, res_d;
    logic            zflag_q, zflag_d;
    logic            out_valid_q, out_valid_d;
    logic            out_illegal_q, out_illegal_d;
    logic [BITS-1:0] out_result_q, out_result_d;
    logic            out_zero_q, out_zero_d;

    // Captured instruction fields
    logic [2:0]      op;
    logic            use_imm;
    logic [1:0]      rd, rs1, rs2;
    logic [BITS-1:0] imm;
    logic            legal;
    logic [BITS-1:0] rs1_val, rs2_val;

    assign op      = instr_q[15:13];
    assign use_imm = instr_q[12];
    assign rd      = instr_q[11:10];
    assign rs1     = instr_q[9:8];
    assign rs2     = instr_q[7:6];
    assign imm     = BITS'(instr_q[7:0]);

    always_comb begin
        legal = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
    end

    // r0 reads as zero; it has no storage
    function automatic logic [BITS-1:0] rf_read(input logic [1:0]      sel,
                                                input logic [BITS-1:0] v1,
                                                input logic [BITS-1:0] v2,
                                                input logic [BITS-1:0] v3);
        logic [BITS-1:0] v;
        v = '0;
        case (sel)
            2'd1:    v = v1;
            2'd2:    v = v2;
            2'd3:    v = v3;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign rs1_val  = rf_read(rs1, r1_q, r2_q, r3_q);
    assign rs2_val  = rf_read(rs2, r1_q, r2_q, r3_q);
    assign dbg_data = rf_read(dbg_sel, r1_q, r2_q, r3_q);

    assign in_ready = (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        r1_d          = r1_q;
        r2_d          = r2_q;
        r3_d          = r3_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        res_d         = res_q;
        zflag_d       = zflag_q;
        out_valid_d   = 1'b0;
        out_illegal_d = 1'b0;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Operands are read here, after any prior write-back, so there are no hazards
                alu_a_d  = rs1_val;
                alu_b_d  = use_imm ? imm : rs2_val;
                alu_op_d = op;
                state_d  = StExec;
            end
            StExec: begin
                res_d   = alu_r;
                zflag_d = alu_zero;
                state_d = StWb;
            end
            StWb: begin
                // Retire outputs are registered, so out_valid appears with the IDLE cycle
                out_valid_d   = 1'b1;
                out_illegal_d = ~legal;
                if (legal) begin
                    out_result_d = res_q;
                    out_zero_d   = zflag_q;
                    case (rd)
                        2'd1:    r1_d = res_q;
                        2'd2:    r2_d = res_q;
                        2'd3:    r3_d = res_q;
                        default: ;
                    endcase
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            r1_q          <= RESET_VAL;
            r2_q          <= RESET_VAL;
            r3_q          <= RESET_VAL;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            res_q         <= '0;
            zflag_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            r1_q          <= r1_d;
            r2_q          <= r2_d;
            r3_q          <= r3_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            res_q         <= res_d;
            zflag_q       <= zflag_d;
            out_valid_q   <= out_valid_d;
            out_illegal_q <= out_illegal_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_valid   = out_valid_q;
    assign out_illegal = out_illegal_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;

`ifdef ALU_SEQ_ZERO_CNT_EN
    logic [7:0] zero_cnt_q, zero_cnt_d;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (state_q == StWb && legal && zflag_q && zero_cnt_q != 8'hFF) begin
            zero_cnt_d = zero_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl. It provides a behavioural ALU and a transaction-level
// reference model (register array plus one in-flight instruction). A per-cycle
// compare process checks the DUT against the model. Directed instructions carry
// hand-computed expectations.

module tb_alu_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [15:0] in_instr;
    logic       in_ready;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic       out_valid;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_illegal;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
`ifdef ALU_SEQ_ZERO_CNT_EN
    logic [7:0] zero_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    alu_seq_ctrl #(
        .BITS      (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_r       (alu_r),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
`ifdef ALU_SEQ_ZERO_CNT_EN
        ,
        .zero_cnt    (zero_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU seen by the sequencer
    always_comb begin
        alu_r = 8'hA5;
        case (alu_op)
            3'd0: alu_r = alu_a + alu_b;
            3'd1: alu_r = alu_a - alu_b;
            3'd2: alu_r = alu_a & alu_b;
            3'd3: alu_r = alu_a | alu_b;
            3'd5: alu_r = (alu_a < alu_b) ? 8'd1 : 8'd0;
            default: alu_r = 8'hA5;
        endcase
    end
    assign alu_zero = (alu_r == 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_reg [4];
    int          cyc = 0;
    bit          p_vld;
    int          p_due;
    logic [15:0] p_ins;
    int          ret_cyc = -1;
    bit          ret_ill;
    logic [7:0]  m_res;
    bit          m_zero;
    int          m_zcnt;

    function automatic bit is_illegal(input logic [2:0] op);
        return (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
    endfunction

    function automatic logic [7:0] ref_res(input logic [15:0] ins);
        logic [7:0] a, b;
        a = m_reg[ins[9:8]];
        b = ins[12] ? ins[7:0] : m_reg[ins[7:6]];
        case (ins[15:13])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (a < b) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] <= 8'h00;
            p_vld   <= 1'b0;
            ret_cyc <= -1;
            ret_ill <= 1'b0;
            m_res   <= 8'h00;
            m_zero  <= 1'b0;
            m_zcnt  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!p_vld && in_valid) begin
                p_vld <= 1'b1;
                p_due <= cyc + 3;
                p_ins <= in_instr;
            end
            if (p_vld && cyc == p_due) begin
                p_vld   <= 1'b0;
                ret_cyc <= cyc + 1;
                ret_ill <= is_illegal(p_ins[15:13]);
                if (!is_illegal(p_ins[15:13])) begin
                    m_res  <= ref_res(p_ins);
                    m_zero <= (ref_res(p_ins) == 8'h00);
                    if (p_ins[11:10] != 2'd0) m_reg[p_ins[11:10]] <= ref_res(p_ins);
                    if (ref_res(p_ins) == 8'h00 && m_zcnt < 255) m_zcnt <= m_zcnt + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", in_ready, !p_vld);
                chk("out_valid", out_valid, (ret_cyc == cyc));
                chk("out_illegal", out_illegal, (ret_cyc == cyc) && ret_ill);
                chk("out_result", out_result, m_res);
                chk("out_zero", out_zero, m_zero);
                chk("dbg_data", dbg_data, m_reg[dbg_sel]);
`ifdef ALU_SEQ_ZERO_CNT_EN
                chk("zero_cnt", zero_cnt, m_zcnt);
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins);
        int n;
        n = 0;
        step();
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
        in_instr = 16'($urandom);
    endtask

    task automatic wait_retire(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!out_valid && k < 8);
        chk({name, "_latency"}, k, 3);
    endtask

    task automatic run_instr(input string name, input logic [15:0] ins,
                             input logic [7:0] res, input logic zero, input logic ill);
        issue(ins);
        wait_retire(name);
        chk({name, "_result"}, out_result, res);
        chk({name, "_zero"}, out_zero, zero);
        chk({name, "_illegal"}, out_illegal, ill);
        step();
        chk({name, "_pulse"}, out_valid, 0);
    endtask

    task automatic dbg_check(input string name, input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        chk(name, dbg_data, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_sel  = 2'd0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_out_result", out_result, 0);
        rst_n = 1'b1;

        run_instr("add_imm", 16'h1405, 8'h05, 1'b0, 1'b0);   // r1 = r0 + 0x05
        dbg_check("dbg_r1_add", 2'd1, 8'h05);
        run_instr("sub_zero", 16'h3905, 8'h00, 1'b1, 1'b0);  // r2 = r1 - 0x05
        dbg_check("dbg_r2_sub", 2'd2, 8'h00);
        run_instr("sub_wrap", 16'h3E01, 8'hFF, 1'b0, 1'b0);  // r3 = r2 - 0x01
        dbg_check("dbg_r3_wrap", 2'd3, 8'hFF);
        run_instr("slt_reg", 16'hA4C0, 8'h01, 1'b0, 1'b0);   // r1 = (r0 < r3)
        dbg_check("dbg_r1_slt", 2'd1, 8'h01);
        run_instr("or_r0", 16'h7130, 8'h31, 1'b0, 1'b0);     // r0 <- r1 | 0x30, dropped
        dbg_check("dbg_r0", 2'd0, 8'h00);
        run_instr("and_imm", 16'h5B0F, 8'h0F, 1'b0, 1'b0);   // r2 = r3 & 0x0F
        run_instr("add_reg", 16'h0FC0, 8'hFE, 1'b0, 1'b0);   // r3 = r3 + r3
        dbg_check("dbg_r3_add", 2'd3, 8'hFE);
        run_instr("sub_z2", 16'h3A0F, 8'h00, 1'b1, 1'b0);    // r2 = r2 - 0x0F
        run_instr("ill_110", 16'hD4AA, 8'h00, 1'b1, 1'b1);
        dbg_check("dbg_r1_ill", 2'd1, 8'h01);
        run_instr("ill_100", 16'h9000, 8'h00, 1'b1, 1'b1);
        run_instr("ill_111", 16'hF000, 8'h00, 1'b1, 1'b1);

        // in_valid held across a whole instruction: a second one is accepted after WB
        step();
        in_valid = 1'b1;
        in_instr = 16'h7130;
        step();
        chk("hold_ready_dec", in_ready, 0);
        step();
        chk("hold_ready_exec", in_ready, 0);
        step();
        chk("hold_ready_wb", in_ready, 0);
        step();
        chk("hold_ready_idle", in_ready, 1);
        chk("hold_retire1", out_valid, 1);
        step();
        chk("hold_ready_dec2", in_ready, 0);
        in_valid = 1'b0;
        wait_retire("hold2");
        chk("hold2_result", out_result, 8'h31);

        // Reset during EXEC drops the instruction
        issue(16'h1877);                                     // r2 = r0 + 0x77
        step();
        chk("pre_rst_alu_b", alu_b, 8'h77);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_illegal", out_illegal, 0);
        chk("mid_rst_out_result", out_result, 0);
        chk("mid_rst_out_zero", out_zero, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        dbg_check("post_rst_r2", 2'd2, 8'h00);
        dbg_check("post_rst_r1", 2'd1, 8'h00);
        repeat (4) step();
        run_instr("post_rst_add", 16'h1405, 8'h05, 1'b0, 1'b0);

`ifdef ALU_SEQ_ZERO_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(16'h2000);                                 // r0 = r0 - r0
            wait_retire("zsub");
        end
        step();
        chk("zero_cnt_sat", zero_cnt, 8'hFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
